// File: rtl/video_pkg.sv
// Shared video-path types and helpers for the overlay stages.
package video_pkg;

  localparam int RGB_W = 24;
  localparam int PIX_W = 8;
  localparam int CNT_W = 12;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Timing plus per-pixel flags that travel together through the read-latency delay.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    rgb_t data;
    logic region;
    logic border;
  } pipe_t;

  // Normalises vsync to "1 = active" whatever the upstream polarity.
  function automatic logic vs_active(input logic vs, input logic pol);
    return (vs == pol);
  endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed-depth shift register with asynchronous active-low clear.
module delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr_q [DEPTH];
  logic [WIDTH-1:0] sr_d [DEPTH];

  always_comb begin
    sr_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/region_overlay.sv
// Composites one grayscale RAM region (with optional 1-pixel frame) onto a passing
// RGB timing stream; requests are issued per pixel and re-aligned after RD_LATENCY.
module region_overlay
  import video_pkg::*;
#(
  parameter int               H_START    = 64,
  parameter int               V_START    = 32,
  parameter int               REGION_W   = 32,
  parameter int               REGION_H   = 32,
  parameter int               RD_LATENCY = 1,
  parameter bit               BORDER_EN  = 1'b0,
  parameter logic [RGB_W-1:0] BORDER_RGB = 24'hFF0000,
  parameter bit               VS_POL     = 1'b1
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             i_hs,
  input  logic             i_vs,
  input  logic             i_de,
  input  logic [RGB_W-1:0] i_data,
  output logic             o_region_active,
  output logic             o_ram_addr_rst,
  input  logic [PIX_W-1:0] i_region_data,
  output logic             o_hs,
  output logic             o_vs,
  output logic             o_de,
  output logic [RGB_W-1:0] o_data
);

  localparam int X_LO = H_START;
  localparam int X_HI = H_START + REGION_W - 1;
  localparam int Y_LO = V_START;
  localparam int Y_HI = V_START + REGION_H - 1;

  logic [CNT_W-1:0] x_cnt_q, x_cnt_d;
  logic [CNT_W-1:0] y_cnt_q, y_cnt_d;
  logic             de_q, de_d;
  logic             vs_act_q, vs_act_d;
  logic             frame_ok_q, frame_ok_d;
  logic             addr_rst_q, addr_rst_d;
  logic             vs_lead, de_fall;
  logic             in_region, in_border;
  int               x_i, y_i;
  pipe_t            pipe_in, pipe_dly;

  logic             o_hs_q, o_hs_d;
  logic             o_vs_q, o_vs_d;
  logic             o_de_q, o_de_d;
  logic [RGB_W-1:0] o_data_q, o_data_d;

  // Position tracking; vs clear takes priority over a coincident de fall.
  always_comb begin
    vs_act_d = vs_active(i_vs, VS_POL);
    vs_lead  = vs_act_d && !vs_act_q;
    de_d     = i_de;
    de_fall  = de_q && !i_de;

    x_cnt_d = '0;
    if (i_de) begin
      x_cnt_d = (x_cnt_q == '1) ? x_cnt_q : x_cnt_q + CNT_W'(1);
    end

    y_cnt_d = y_cnt_q;
    if (vs_lead) begin
      y_cnt_d = '0;
    end else if (de_fall && (y_cnt_q != '1)) begin
      y_cnt_d = y_cnt_q + CNT_W'(1);
    end

    // After a reset nothing is emitted until a full frame begins.
    frame_ok_d = frame_ok_q || vs_lead;
    addr_rst_d = vs_lead;
  end

  // Window decode in signed arithmetic so the frame's -1 bound clips at column/line 0.
  always_comb begin
    x_i = {{(32-CNT_W){1'b0}}, x_cnt_q};
    y_i = {{(32-CNT_W){1'b0}}, y_cnt_q};

    in_region = i_de && frame_ok_q &&
                (x_i >= X_LO) && (x_i <= X_HI) &&
                (y_i >= Y_LO) && (y_i <= Y_HI);

    in_border = BORDER_EN && i_de && frame_ok_q && !in_region &&
                (x_i >= X_LO - 1) && (x_i <= X_HI + 1) &&
                (y_i >= Y_LO - 1) && (y_i <= Y_HI + 1);

    pipe_in = '0;
    if (frame_ok_d) begin
      pipe_in.hs     = i_hs;
      pipe_in.vs     = i_vs;
      pipe_in.de     = i_de;
      pipe_in.data   = i_data;
      pipe_in.region = in_region;
      pipe_in.border = in_border;
    end
  end

  delay_line #(
    .DEPTH (RD_LATENCY),
    .WIDTH ($bits(pipe_t))
  ) u_delay (
    .clk   (pclk),
    .rst_n (rst_n),
    .din   (pipe_in),
    .dout  (pipe_dly)
  );

  always_comb begin
    o_hs_d   = pipe_dly.hs;
    o_vs_d   = pipe_dly.vs;
    o_de_d   = pipe_dly.de;
    o_data_d = '0;
    if (pipe_dly.de) begin
      if (pipe_dly.region) begin
        o_data_d = {3{i_region_data}};
      end else if (pipe_dly.border) begin
        o_data_d = BORDER_RGB;
      end else begin
        o_data_d = pipe_dly.data;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt_q    <= '0;
      y_cnt_q    <= '0;
      de_q       <= 1'b0;
      vs_act_q   <= 1'b0;
      frame_ok_q <= 1'b0;
      addr_rst_q <= 1'b0;
      o_hs_q     <= 1'b0;
      o_vs_q     <= 1'b0;
      o_de_q     <= 1'b0;
      o_data_q   <= '0;
    end else begin
      x_cnt_q    <= x_cnt_d;
      y_cnt_q    <= y_cnt_d;
      de_q       <= de_d;
      vs_act_q   <= vs_act_d;
      frame_ok_q <= frame_ok_d;
      addr_rst_q <= addr_rst_d;
      o_hs_q     <= o_hs_d;
      o_vs_q     <= o_vs_d;
      o_de_q     <= o_de_d;
      o_data_q   <= o_data_d;
    end
  end

  assign o_region_active = in_region;
  assign o_ram_addr_rst  = addr_rst_q;
  assign o_hs            = o_hs_q;
  assign o_vs            = o_vs_q;
  assign o_de            = o_de_q;
  assign o_data          = o_data_q;

endmodule

// File: tb/tb_region_overlay.sv
// Directed bench for region_overlay: five parameterisations share one reduced-width
// video stream (160 active pixels/line, 70 active lines) and are checked against hand values.
module tb_region_overlay;

  localparam int NI    = 5;
  localparam int HA    = 160;
  localparam int HB    = 10;
  localparam int LINE  = HA + HB;
  localparam int LINES = 70;
  localparam int LOGN  = 65536;
  localparam int LAT [NI] = '{1, 3, 1, 1, 1};

  // ---------------- clock / reset ----------------
  logic pclk  = 1'b0;
  logic rst_n = 1'b0;
  always #5 pclk = ~pclk;

  logic        i_hs = 1'b0, i_vs = 1'b0, i_de = 1'b0;
  logic [23:0] i_data = 24'h0;

  logic        act      [NI];
  logic        addr_rst [NI];
  logic [7:0]  rdat     [NI];
  logic        o_hs     [NI];
  logic        o_vs     [NI];
  logic        o_de     [NI];
  logic [23:0] o_data   [NI];

  // u0 default, u1 deeper read latency, u2 framed, u3 framed at column 0,
  // u4 window running past the line end (150+32 > 160).
  region_overlay #(.H_START(64), .V_START(32), .REGION_W(32), .REGION_H(32), .RD_LATENCY(1),
                   .BORDER_EN(1'b0), .BORDER_RGB(24'hFF0000), .VS_POL(1'b1)) u0 (
    .pclk(pclk), .rst_n(rst_n), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_data(i_data),
    .o_region_active(act[0]), .o_ram_addr_rst(addr_rst[0]), .i_region_data(rdat[0]),
    .o_hs(o_hs[0]), .o_vs(o_vs[0]), .o_de(o_de[0]), .o_data(o_data[0]));
  region_overlay #(.RD_LATENCY(3)) u1 (
    .pclk(pclk), .rst_n(rst_n), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_data(i_data),
    .o_region_active(act[1]), .o_ram_addr_rst(addr_rst[1]), .i_region_data(rdat[1]),
    .o_hs(o_hs[1]), .o_vs(o_vs[1]), .o_de(o_de[1]), .o_data(o_data[1]));
  region_overlay #(.BORDER_EN(1'b1), .BORDER_RGB(24'h00FF00)) u2 (
    .pclk(pclk), .rst_n(rst_n), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_data(i_data),
    .o_region_active(act[2]), .o_ram_addr_rst(addr_rst[2]), .i_region_data(rdat[2]),
    .o_hs(o_hs[2]), .o_vs(o_vs[2]), .o_de(o_de[2]), .o_data(o_data[2]));
  region_overlay #(.H_START(0), .BORDER_EN(1'b1), .BORDER_RGB(24'h00FF00)) u3 (
    .pclk(pclk), .rst_n(rst_n), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_data(i_data),
    .o_region_active(act[3]), .o_ram_addr_rst(addr_rst[3]), .i_region_data(rdat[3]),
    .o_hs(o_hs[3]), .o_vs(o_vs[3]), .o_de(o_de[3]), .o_data(o_data[3]));
  region_overlay #(.H_START(150)) u4 (
    .pclk(pclk), .rst_n(rst_n), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_data(i_data),
    .o_region_active(act[4]), .o_ram_addr_rst(addr_rst[4]), .i_region_data(rdat[4]),
    .o_hs(o_hs[4]), .o_vs(o_vs[4]), .o_de(o_de[4]), .o_data(o_data[4]));

  // ---------------- RAM model and cycle counter ----------------
  int         cyc = 0;
  logic [7:0] rp       [NI][4] = '{default: '0};
  int         req_idx  [NI] = '{default: 0};
  int         req_cnt  [NI] = '{default: 0};
  int         addr_cnt [NI] = '{default: 0};

  always @(posedge pclk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < NI; k++) begin
      rp[k][0] <= act[k] ? 8'(req_idx[k]) : 8'h00;
      for (int j = 1; j < 4; j++) rp[k][j] <= rp[k][j-1];
      if (addr_rst[k]) req_idx[k] <= 0;
      else if (act[k]) req_idx[k] <= req_idx[k] + 1;
      if (act[k])      req_cnt[k]  <= req_cnt[k] + 1;
      if (addr_rst[k]) addr_cnt[k] <= addr_cnt[k] + 1;
    end
  end

  always_comb begin
    for (int k = 0; k < NI; k++) rdat[k] = rp[k][LAT[k]-1];
  end

  // ---------------- per-cycle logs, sampled mid-cycle ----------------
  logic        l_ihs [LOGN];
  logic        l_ivs [LOGN];
  logic        l_ide [LOGN];
  logic        l_addr [LOGN];
  logic        l_ohs [NI][LOGN];
  logic        l_ovs [NI][LOGN];
  logic        l_ode [NI][LOGN];
  logic [23:0] l_odat [NI][LOGN];

  always @(negedge pclk) begin
    if (cyc < LOGN) begin
      l_ihs[cyc]  <= i_hs;
      l_ivs[cyc]  <= i_vs;
      l_ide[cyc]  <= i_de;
      l_addr[cyc] <= addr_rst[0];
      for (int k = 0; k < NI; k++) begin
        l_ohs[k][cyc]  <= o_hs[k];
        l_ovs[k][cyc]  <= o_vs[k];
        l_ode[k][cyc]  <= o_de[k];
        l_odat[k][cyc] <= o_data[k];
      end
    end
  end

  // ---------------- scoreboard state ----------------
  int          checks   = 0;
  int          failures = 0;
  int          px_cyc [LINES][HA];
  int          vs0, fend, rel_cyc, rel_req;
  logic [28:0] snap;
  int          base_req [NI];
  int          base_addr;

  // ---------------- driver tasks ----------------
  task automatic tick(input logic hs, input logic vs, input logic de, input logic [23:0] d);
    @(posedge pclk);
    #1;
    i_hs = hs; i_vs = vs; i_de = de; i_data = d;
  endtask

  // One frame: 2 vs lines, 2 back-porch lines, LINES active lines, 1 front-porch line.
  // When rl >= 0, rst_n is pulsed low for 3 cycles starting at pixel (rl, rx).
  task automatic drive_frame(input int rl, input int rx);
    int rst_left;
    rst_left = 0;
    for (int i = 0; i < 2*LINE; i++) begin
      tick(1'b0, 1'b1, 1'b0, 24'h0);
      if (i == 0) vs0 = cyc;
    end
    for (int i = 0; i < 2*LINE; i++) tick(1'b0, 1'b0, 1'b0, 24'h0);
    for (int y = 0; y < LINES; y++) begin
      for (int b = 0; b < HB; b++) tick((b >= 1) && (b <= 4), 1'b0, 1'b0, 24'h0);
      for (int x = 0; x < HA; x++) begin
        tick(1'b0, 1'b0, 1'b1, {8'(y), 8'(x), 8'h5A});
        px_cyc[y][x] = cyc;
        if (rst_left > 0) begin
          rst_left--;
          if (rst_left == 0) begin
            #1 rst_n = 1'b1;
            rel_cyc = cyc;
            rel_req = req_cnt[0];
          end
        end else if (y == rl && x == rx) begin
          #1 rst_n = 1'b0;
          #1 snap = {o_hs[0], o_vs[0], o_de[0], o_data[0], act[0], addr_rst[0]};
          rst_left = 3;
        end
      end
    end
    for (int i = 0; i < LINE; i++) tick(1'b0, 1'b0, 1'b0, 24'h0);
    fend = cyc;
  endtask

  task automatic snap_bases();
    for (int k = 0; k < NI; k++) base_req[k] = req_cnt[k];
    base_addr = addr_cnt[0];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [28:0] obs;
    rst_n = 1'b0;
    repeat (5) @(posedge pclk);
    #1;
    obs = {o_hs[0], o_vs[0], o_de[0], o_data[0], act[0], addr_rst[0]};
    checks++;
    if (obs !== 29'h0) begin
      failures++; $display("FAIL reset_outputs: got %h want 0", obs);
    end
    #2 rst_n = 1'b1;
    repeat (20) tick(1'b0, 1'b0, 1'b0, 24'h0);
    checks++;
    if (addr_cnt[0] !== 0) begin
      failures++; $display("FAIL addr_rst_at_release: got %0d pulses want 0", addr_cnt[0]);
    end
    checks++;
    if (req_cnt[0] !== 0) begin
      failures++; $display("FAIL req_before_frame: got %0d want 0", req_cnt[0]);
    end
  endtask

  task automatic test_region_frame();
    int exp_cnt [NI];
    int c;
    exp_cnt = '{1024, 1024, 1024, 1024, 320};
    snap_bases();
    drive_frame(-1, 0);
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (req_cnt[k] - base_req[k] !== exp_cnt[k]) begin
        failures++;
        $display("FAIL req_count_u%0d: got %0d want %0d", k, req_cnt[k] - base_req[k], exp_cnt[k]);
      end
    end
    c = px_cyc[32][64] + 2;
    checks++;
    if (l_odat[0][c] !== 24'h000000) begin
      failures++; $display("FAIL pix_32_64: got %h want 000000", l_odat[0][c]);
    end
    c = px_cyc[32][95] + 2;
    checks++;
    if (l_odat[0][c] !== 24'h1F1F1F) begin
      failures++; $display("FAIL pix_32_95: got %h want 1f1f1f", l_odat[0][c]);
    end
    c = px_cyc[32][96] + 2;
    checks++;
    if (l_odat[0][c] !== 24'h20605A) begin
      failures++; $display("FAIL pix_32_96: got %h want 20605a", l_odat[0][c]);
    end
    c = px_cyc[33][64] + 2;
    checks++;
    if (l_odat[0][c] !== 24'h202020) begin
      failures++; $display("FAIL pix_33_64: got %h want 202020", l_odat[0][c]);
    end
    c = px_cyc[63][95] + 2;
    checks++;
    if (l_odat[0][c] !== 24'hFFFFFF) begin
      failures++; $display("FAIL pix_63_95: got %h want ffffff", l_odat[0][c]);
    end
    c = px_cyc[32][0] - 1 + 2;
    checks++;
    if (l_odat[0][c] !== 24'h0 || l_ode[0][c] !== 1'b0) begin
      failures++; $display("FAIL blank_data: got de=%b data=%h want 0/0", l_ode[0][c], l_odat[0][c]);
    end
    c = px_cyc[32][95] + 4;
    checks++;
    if (l_odat[1][c] !== 24'h1F1F1F) begin
      failures++; $display("FAIL lat3_pix_32_95: got %h want 1f1f1f", l_odat[1][c]);
    end
    c = px_cyc[40][70] + 4;
    checks++;
    if (l_odat[1][c] !== 24'h060606) begin
      failures++; $display("FAIL lat3_pix_40_70: got %h want 060606", l_odat[1][c]);
    end
  endtask

  task automatic test_timing_delay();
    int e0, e1, e4;
    e0 = 0; e1 = 0; e4 = 0;
    for (int k = vs0; k + 4 < fend; k++) begin
      if ({l_ohs[0][k+2], l_ovs[0][k+2], l_ode[0][k+2]} !== {l_ihs[k], l_ivs[k], l_ide[k]}) e0++;
      if ({l_ohs[1][k+4], l_ovs[1][k+4], l_ode[1][k+4]} !== {l_ihs[k], l_ivs[k], l_ide[k]}) e1++;
      if (l_ode[4][k+2] !== l_ide[k]) e4++;
    end
    checks++;
    if (e0 !== 0) begin
      failures++; $display("FAIL delay2_timing: got %0d mismatched cycles want 0", e0);
    end
    checks++;
    if (e1 !== 0) begin
      failures++; $display("FAIL delay4_timing: got %0d mismatched cycles want 0", e1);
    end
    checks++;
    if (e4 !== 0) begin
      failures++; $display("FAIL line_end_de: got %0d mismatched cycles want 0", e4);
    end
  endtask

  task automatic test_addr_rst();
    int n;
    n = 0;
    for (int k = vs0 - 2; k < fend; k++) if (l_addr[k] === 1'b1) n++;
    checks++;
    if (n !== 1) begin
      failures++; $display("FAIL addr_rst_count: got %0d want 1", n);
    end
    checks++;
    if ({l_addr[vs0], l_addr[vs0+1], l_addr[vs0+2]} !== 3'b010) begin
      failures++;
      $display("FAIL addr_rst_timing: got %b want 010", {l_addr[vs0], l_addr[vs0+1], l_addr[vs0+2]});
    end
  endtask

  task automatic test_border();
    int e;
    int c;
    e = 0;
    for (int x = 63; x <= 96; x++) begin
      if (l_odat[2][px_cyc[31][x] + 2] !== 24'h00FF00) e++;
      if (l_odat[2][px_cyc[64][x] + 2] !== 24'h00FF00) e++;
    end
    for (int y = 32; y <= 63; y++) begin
      if (l_odat[2][px_cyc[y][63] + 2] !== 24'h00FF00) e++;
      if (l_odat[2][px_cyc[y][96] + 2] !== 24'h00FF00) e++;
    end
    checks++;
    if (e !== 0) begin
      failures++; $display("FAIL border_frame: got %0d wrong pixels want 0", e);
    end
    c = px_cyc[31][62] + 2;
    checks++;
    if (l_odat[2][c] !== 24'h1F3E5A) begin
      failures++; $display("FAIL border_outside_31_62: got %h want 1f3e5a", l_odat[2][c]);
    end
    c = px_cyc[32][97] + 2;
    checks++;
    if (l_odat[2][c] !== 24'h20615A) begin
      failures++; $display("FAIL border_outside_32_97: got %h want 20615a", l_odat[2][c]);
    end
    c = px_cyc[32][64] + 2;
    checks++;
    if (l_odat[2][c] !== 24'h000000) begin
      failures++; $display("FAIL border_region_32_64: got %h want 000000", l_odat[2][c]);
    end
    c = px_cyc[31][0] + 2;
    checks++;
    if (l_odat[3][c] !== 24'h00FF00) begin
      failures++; $display("FAIL col0_border_31_0: got %h want 00ff00", l_odat[3][c]);
    end
    c = px_cyc[32][0] + 2;
    checks++;
    if (l_odat[3][c] !== 24'h000000) begin
      failures++; $display("FAIL col0_region_32_0: got %h want 000000", l_odat[3][c]);
    end
    c = px_cyc[32][32] + 2;
    checks++;
    if (l_odat[3][c] !== 24'h00FF00) begin
      failures++; $display("FAIL col0_border_32_32: got %h want 00ff00", l_odat[3][c]);
    end
    c = px_cyc[32][33] + 2;
    checks++;
    if (l_odat[3][c] !== 24'h20215A) begin
      failures++; $display("FAIL col0_pass_32_33: got %h want 20215a", l_odat[3][c]);
    end
    c = px_cyc[32][0] - 1 + 2;
    checks++;
    if (l_odat[3][c] !== 24'h0) begin
      failures++; $display("FAIL col0_no_left_border: got %h want 000000", l_odat[3][c]);
    end
  endtask

  task automatic test_reset_midframe();
    int ones;
    snap_bases();
    drive_frame(40, 70);
    checks++;
    if (snap !== 29'h0) begin
      failures++; $display("FAIL async_reset_outputs: got %h want 0", snap);
    end
    checks++;
    if (rel_req - base_req[0] !== 262) begin
      failures++; $display("FAIL req_before_reset: got %0d want 262", rel_req - base_req[0]);
    end
    checks++;
    if (req_cnt[0] - rel_req !== 0) begin
      failures++; $display("FAIL req_after_reset: got %0d want 0", req_cnt[0] - rel_req);
    end
    ones = 0;
    for (int k = rel_cyc; k < fend; k++) if (l_ode[0][k] !== 1'b0) ones++;
    checks++;
    if (ones !== 0) begin
      failures++; $display("FAIL de_after_reset: got %0d active cycles want 0", ones);
    end
  endtask

  task automatic test_back_to_back();
    snap_bases();
    drive_frame(-1, 0);
    checks++;
    if (req_cnt[0] - base_req[0] !== 1024) begin
      failures++; $display("FAIL recover_req_u0: got %0d want 1024", req_cnt[0] - base_req[0]);
    end
    checks++;
    if (req_cnt[4] - base_req[4] !== 320) begin
      failures++; $display("FAIL recover_req_u4: got %0d want 320", req_cnt[4] - base_req[4]);
    end
    checks++;
    if (addr_cnt[0] - base_addr !== 1) begin
      failures++; $display("FAIL recover_addr_rst: got %0d want 1", addr_cnt[0] - base_addr);
    end
    checks++;
    if (l_odat[0][px_cyc[63][95] + 2] !== 24'hFFFFFF) begin
      failures++; $display("FAIL recover_pix_63_95: got %h want ffffff", l_odat[0][px_cyc[63][95] + 2]);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_region_frame();
    test_timing_delay();
    test_addr_rst();
    test_border();
    test_reset_midframe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
